// File: rtl/rr_arbiter_4req_pkg.sv
// Shared definitions for the four-requester round-robin / fixed-priority arbiter.
package rr_arbiter_4req_pkg;

  localparam int unsigned NUM_REQ          = 4;
  localparam int unsigned DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Bits strictly below ptr; zero when ptr == 0.
  function automatic logic [NUM_REQ-1:0] below_mask(input logic [1:0] ptr);
    return (4'b0001 << ptr) - 4'b0001;
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/priority_encoder_4bit.sv
// 4-bit priority encoder: index of the highest set bit, valid when any bit is set.
module priority_encoder_4bit
  import rr_arbiter_4req_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  output logic [1:0]         idx,
  output logic               valid
);

  always_comb begin
    valid = |vec;
    idx   = 2'd0;
    if (vec[3]) begin
      idx = 2'd3;
    end else if (vec[2]) begin
      idx = 2'd2;
    end else if (vec[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd0;
    end
  end

endmodule

// File: rtl/rr_arbiter_4req.sv
// Four-requester arbiter with fixed or round-robin priority, grant hold and a
// hold-time limit that forces rotation when other requesters are waiting.
module rr_arbiter_4req
  import rr_arbiter_4req_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rr_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               gnt_valid,
  output logic [CNT_W-1:0]   hold_cnt
);

  localparam int unsigned HoldLastInt = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HoldLastInt);

  if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $fatal(1, "CNT_W too narrow for MAX_HOLD");
  end

  arb_state_e          state;
  logic [1:0]          last;
  logic [NUM_REQ-1:0]  cand;
  logic                want_arb;
  logic                arb;
  logic                go_idle;
  logic                at_limit;
  logic                hold_sat;
  logic [1:0]          m_idx;
  logic                m_valid;
  logic [1:0]          u_idx;
  logic                u_valid;
  logic [1:0]          winner;

  priority_encoder_4bit u_enc_masked (
    .vec   (cand & below_mask(last)),
    .idx   (m_idx),
    .valid (m_valid)
  );

  priority_encoder_4bit u_enc_full (
    .vec   (cand),
    .idx   (u_idx),
    .valid (u_valid)
  );

  // Round-robin prefers requesters below the last winner, then wraps to the top.
  assign winner = (rr_en && m_valid) ? m_idx : u_idx;

  assign at_limit = (MAX_HOLD != 0) && (hold_cnt == HoldLast);
  // With no limit the counter just parks at its maximum instead of wrapping.
  assign hold_sat = (MAX_HOLD != 0) ? at_limit : (&hold_cnt);

  always_comb begin
    cand     = req;
    want_arb = 1'b0;
    if (state == IDLE) begin
      want_arb = 1'b1;
    end else if (!req[gnt_id]) begin
      want_arb = 1'b1;
    end else if (at_limit && |(req & ~gnt)) begin
      want_arb = 1'b1;
      cand     = req & ~gnt;
    end
  end

  assign arb     = want_arb && u_valid;
  assign go_idle = want_arb && !u_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 2'd0;
      gnt       <= '0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end else if (arb) begin
      state     <= GRANT;
      last      <= winner;
      gnt       <= to_onehot(winner);
      gnt_id    <= winner;
      gnt_valid <= 1'b1;
      hold_cnt  <= '0;
    end else if (go_idle) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end else if (state == GRANT && !hold_sat) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// Directed bench: one arbiter with an 8-cycle hold limit and one with the limit disabled.
module tb_rr_arbiter_4req;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rr_en;

  logic [3:0] a_gnt;
  logic [1:0] a_id;
  logic       a_valid;
  logic [3:0] a_hold;
  logic [3:0] z_gnt;
  logic [1:0] z_id;
  logic       z_valid;
  logic [3:0] z_hold;

  int vectors = 0;
  int errors  = 0;

  rr_arbiter_4req #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rr_en     (rr_en),
    .gnt       (a_gnt),
    .gnt_id    (a_id),
    .gnt_valid (a_valid),
    .hold_cnt  (a_hold)
  );

  rr_arbiter_4req #(.MAX_HOLD(0), .CNT_W(4)) dut_nolimit (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rr_en     (rr_en),
    .gnt       (z_gnt),
    .gnt_id    (z_id),
    .gnt_valid (z_valid),
    .hold_cnt  (z_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic v, input logic [3:0] h);
    check({tag, ".gnt"}, {4'd0, a_gnt}, {4'd0, g});
    check({tag, ".id"}, {6'd0, a_id}, {6'd0, id});
    check({tag, ".valid"}, {7'd0, a_valid}, {7'd0, v});
    check({tag, ".hold"}, {4'd0, a_hold}, {4'd0, h});
  endtask

  int seq [5] = '{3, 2, 1, 0, 3};

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    rr_en = 1'b0;

    // Reset and idle
    #3;
    check_a("rst_async", 4'b0000, 2'd0, 1'b0, 4'd0);
    #10;
    check_a("rst_held", 4'b0000, 2'd0, 1'b0, 4'd0);
    check("rst_held_nolim", {4'd0, z_gnt}, 8'h00);
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    check_a("idle", 4'b0000, 2'd0, 1'b0, 4'd0);

    // Fixed priority
    req = 4'b0101;
    #1;
    check("fix_no_comb", {4'd0, a_gnt}, 8'h00);
    tick();
    check_a("fix_first", 4'b0100, 2'd2, 1'b1, 4'd0);
    req = 4'b0001;
    tick();
    check_a("fix_handoff", 4'b0001, 2'd0, 1'b1, 4'd0);
    req = 4'b0000;
    tick();
    check_a("fix_release", 4'b0000, 2'd0, 1'b0, 4'd0);

    // Round-robin fairness on the unlimited instance
    rr_en = 1'b1;
    req   = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_gnt%0d", k), {4'd0, z_gnt}, 8'(4'b0001 << seq[k]));
      check($sformatf("rr_id%0d", k), {6'd0, z_id}, 8'(seq[k]));
      check($sformatf("rr_hold0_%0d", k), {4'd0, z_hold}, 8'd0);
      req = 4'b1111;
      tick();
      check($sformatf("rr_hold1_%0d", k), {4'd0, z_hold}, 8'd1);
      if (k < 4) begin
        req = 4'b1111 & ~(4'b0001 << seq[k]);
        tick();
      end
    end
    req = 4'b0000;
    tick();
    check("rr_idle", {7'd0, z_valid}, 8'd0);

    // Hold limit in fixed mode
    rr_en = 1'b0;
    req   = 4'b1001;
    tick();
    check_a("lim_first", 4'b1000, 2'd3, 1'b1, 4'd0);
    repeat (7) tick();
    check_a("lim_at7", 4'b1000, 2'd3, 1'b1, 4'd7);
    tick();
    check_a("lim_rotate", 4'b0001, 2'd0, 1'b1, 4'd0);
    check("lim_nolim_keeps", {4'd0, z_gnt}, 8'b0000_1000);
    repeat (7) tick();
    check_a("lim_owner0_at7", 4'b0001, 2'd0, 1'b1, 4'd7);
    tick();
    check_a("lim_back", 4'b1000, 2'd3, 1'b1, 4'd0);
    req = 4'b0000;
    tick();
    check_a("lim_idle", 4'b0000, 2'd0, 1'b0, 4'd0);

    // Saturation with a single requester
    req = 4'b0010;
    tick();
    check_a("sat_first", 4'b0010, 2'd1, 1'b1, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("sat_gnt%0d", i), {4'd0, a_gnt}, 8'b0000_0010);
      check($sformatf("sat_hold%0d", i), {4'd0, a_hold}, 8'((i < 7) ? i : 7));
    end

    // Asynchronous reset mid-grant
    rr_en = 1'b1;
    req   = 4'b0100;
    tick();
    check_a("ar_owner2", 4'b0100, 2'd2, 1'b1, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    check_a("ar_cleared", 4'b0000, 2'd0, 1'b0, 4'd0);
    #2 rst_n = 1'b1;
    tick();
    check_a("ar_regrant", 4'b0100, 2'd2, 1'b1, 4'd0);
    req = 4'b0000;
    tick();
    // A fresh reset must bring the round-robin pointer back to 0
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req = 4'b1001;
    tick();
    check_a("ar_rr_restart", 4'b1000, 2'd3, 1'b1, 4'd0);
    check("ar_rr_restart_nolim", {4'd0, z_gnt}, 8'b0000_1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
